// File: rtl/frv_dmem_arbiter.sv
// Two-port arbiter for the core data memory bus: LSU (port 0) and secondary master (port 1).
// Optional aging priority for port 1 is enabled with `define FRV_DMEM_ARB_AGING_EN.
module frv_dmem_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int MAX_WAIT    = 8
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        p0_req,
    input  logic        p0_wen,
    input  logic [3:0]  p0_strb,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_recv,
    output logic [31:0] p0_rdata,
    output logic        p0_error,

    input  logic        p1_req,
    input  logic        p1_wen,
    input  logic [3:0]  p1_strb,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_recv,
    output logic [31:0] p1_rdata,
    output logic        p1_error,

    output logic        dmem_req,
    output logic        dmem_wen,
    output logic [3:0]  dmem_strb,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_recv,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_error,

    output logic        arb_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } sel_state_t;

    localparam logic [2:0] CNT_MAX = 3'(OUTSTANDING);

    sel_state_t             sel_state;
    sel_state_t             sel_state_d;
    logic                   sel_port;
    logic                   sel_req;
    logic                   fifo_full;
    logic                   grant;
    logic                   do_pop;
    logic                   head_id;
    logic                   age_hit;
    logic [2:0]             cnt_q;
    logic [2:0]             cnt_d;
    logic [2:0]             wr_idx;
    logic [OUTSTANDING-1:0] fifo_q;
    logic [OUTSTANDING-1:0] fifo_d;

`ifdef FRV_DMEM_ARB_AGING_EN
    logic [3:0] wait_cnt;

    // Saturates so a long-starved port 1 keeps its aging priority.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wait_cnt <= 4'd0;
        end else if (p1_gnt) begin
            wait_cnt <= 4'd0;
        end else if (p1_req && (wait_cnt != 4'hf)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign age_hit = (32'(wait_cnt) >= 32'(MAX_WAIT));
`else
    assign age_hit = (MAX_WAIT < 0);
`endif

    always_comb begin
        sel_port = 1'b0;
        sel_req  = 1'b0;
        case (sel_state)
            LOCK0: begin
                sel_port = 1'b0;
                sel_req  = p0_req;
            end
            LOCK1: begin
                sel_port = 1'b1;
                sel_req  = p1_req;
            end
            default: begin
                sel_port = p1_req && (age_hit || !p0_req);
                sel_req  = p0_req || p1_req;
            end
        endcase
    end

    assign fifo_full  = (cnt_q == CNT_MAX);
    assign dmem_req   = sel_req && !fifo_full;
    assign dmem_wen   = sel_port ? p1_wen   : p0_wen;
    assign dmem_strb  = sel_port ? p1_strb  : p0_strb;
    assign dmem_addr  = sel_port ? p1_addr  : p0_addr;
    assign dmem_wdata = sel_port ? p1_wdata : p0_wdata;

    assign grant  = dmem_req && dmem_gnt;
    assign p0_gnt = grant && !sel_port;
    assign p1_gnt = grant && sel_port;

    // A dropped request while locked releases the lock; a full FIFO holds it.
    always_comb begin
        sel_state_d = sel_state;
        if (!sel_req) begin
            sel_state_d = IDLE;
        end else if (fifo_full) begin
            sel_state_d = sel_state;
        end else if (dmem_gnt) begin
            sel_state_d = IDLE;
        end else begin
            sel_state_d = sel_port ? LOCK1 : LOCK0;
        end
    end

    assign do_pop  = dmem_recv && (cnt_q != 3'd0);
    assign head_id = fifo_q[0];

    // Shift FIFO: head at bit 0; a same-cycle pop moves the write slot down by one.
    always_comb begin
        fifo_d = fifo_q;
        wr_idx = cnt_q;
        if (do_pop) begin
            fifo_d = fifo_q >> 1;
            wr_idx = cnt_q - 3'd1;
        end
        if (grant) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                if (i == int'(wr_idx)) begin
                    fifo_d[i] = sel_port;
                end
            end
        end
        cnt_d = cnt_q + {2'b00, grant} - {2'b00, do_pop};
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            sel_state <= IDLE;
            cnt_q     <= 3'd0;
            fifo_q    <= '0;
            arb_err   <= 1'b0;
        end else begin
            sel_state <= sel_state_d;
            cnt_q     <= cnt_d;
            fifo_q    <= fifo_d;
            if (dmem_recv && (cnt_q == 3'd0)) begin
                arb_err <= 1'b1;
            end
        end
    end

    assign p0_recv  = do_pop && !head_id;
    assign p1_recv  = do_pop && head_id;
    assign p0_rdata = p0_recv ? dmem_rdata : 32'd0;
    assign p1_rdata = p1_recv ? dmem_rdata : 32'd0;
    assign p0_error = p0_recv && dmem_error;
    assign p1_error = p1_recv && dmem_error;

    assign dbg_state = sel_state;

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// Self-checking bench for frv_dmem_arbiter: directed bus cycles with an in-order
// scoreboard of expected response destinations.
module tb_frv_dmem_arbiter;

    logic        g_clk;
    logic        g_reset;
    logic        p0_req, p0_wen, p0_gnt, p0_recv, p0_error;
    logic [3:0]  p0_strb;
    logic [31:0] p0_addr, p0_wdata, p0_rdata;
    logic        p1_req, p1_wen, p1_gnt, p1_recv, p1_error;
    logic [3:0]  p1_strb;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_error;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        arb_err;
    logic [1:0]  dbg_state;

`ifdef FRV_DMEM_ARB_AGING_EN
    localparam bit AGING = 1'b1;
`else
    localparam bit AGING = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q[$];

    frv_dmem_arbiter #(.OUTSTANDING(2), .MAX_WAIT(8)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_strb(p0_strb), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_recv(p0_recv), .p0_rdata(p0_rdata),
        .p0_error(p0_error),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_strb(p1_strb), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_recv(p1_recv), .p1_rdata(p1_rdata),
        .p1_error(p1_error),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
        .arb_err(arb_err), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_reset();
        g_reset = 1'b1;
        exp_q.delete();
        tick();
        tick();
        g_reset = 1'b0;
    endtask

    // One bus cycle: drive bus inputs, check outputs at negedge, update the scoreboard.
    task automatic bus_cycle(input logic gnt, input logic recv, input logic [31:0] rdata,
                             input logic exp_req, input logic [1:0] exp_gnt,
                             input logic [31:0] exp_addr);
        logic err;
        logic exp_port;
        err        = 1'($urandom_range(0, 1));
        dmem_gnt   = gnt;
        dmem_recv  = recv;
        dmem_rdata = rdata;
        dmem_error = err;
        @(negedge g_clk);
        check("dmem_req", dmem_req, exp_req);
        if (exp_req) check("dmem_addr", dmem_addr, exp_addr);
        check("p0_gnt", p0_gnt, exp_gnt[0]);
        check("p1_gnt", p1_gnt, exp_gnt[1]);
        if (recv && exp_q.size() != 0) begin
            exp_port = exp_q.pop_front();
            check("p0_recv", p0_recv, !exp_port);
            check("p1_recv", p1_recv, exp_port);
            check("p0_rdata", p0_rdata, exp_port ? 32'd0 : rdata);
            check("p1_rdata", p1_rdata, exp_port ? rdata : 32'd0);
            check("p0_error", p0_error, !exp_port && err);
            check("p1_error", p1_error, exp_port && err);
        end else begin
            check("p0_recv_idle", p0_recv, 1'b0);
            check("p1_recv_idle", p1_recv, 1'b0);
        end
        if (exp_gnt[0]) exp_q.push_back(1'b0);
        if (exp_gnt[1]) exp_q.push_back(1'b1);
        tick();
        dmem_gnt   = 1'b0;
        dmem_recv  = 1'b0;
        dmem_rdata = 32'd0;
        dmem_error = 1'b0;
    endtask

    initial begin : stim
        logic       exp_sel;
        logic       p1_granted;
        int         p1_wait;
        g_reset = 1'b1;
        p0_req = 1'b0; p0_wen = 1'b0; p0_strb = 4'h0; p0_addr = 32'd0; p0_wdata = 32'd0;
        p1_req = 1'b0; p1_wen = 1'b0; p1_strb = 4'h0; p1_addr = 32'd0; p1_wdata = 32'd0;
        dmem_gnt = 1'b0; dmem_recv = 1'b0; dmem_rdata = 32'd0; dmem_error = 1'b0;
        do_reset();
        check("reset_state", dbg_state, 2'd0);
        check("reset_req", dmem_req, 1'b0);
        check("reset_arb_err", arb_err, 1'b0);

        // Single port 0 load
        p0_req = 1'b1; p0_addr = 32'h0000_2000; p0_strb = 4'hf;
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b01, 32'h0000_2000);
        p0_req = 1'b0;
        bus_cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'd0);

        // Lock hold on port 1 while port 0 arrives
        p1_req = 1'b1; p1_addr = 32'h100; p1_wen = 1'b1; p1_wdata = 32'hCAFE_F00D; p1_strb = 4'h3;
        bus_cycle(1'b0, 1'b0, $urandom(), 1'b1, 2'b00, 32'h100);
        check("lock_state", dbg_state, 2'd2);
        p0_req = 1'b1; p0_addr = 32'h200; p0_wen = 1'b0;
        check("lock_wdata", dmem_wdata, 32'hCAFE_F00D);
        check("lock_wen", dmem_wen, 1'b1);
        check("lock_strb", dmem_strb, 4'h3);
        bus_cycle(1'b0, 1'b0, $urandom(), 1'b1, 2'b00, 32'h100);
        bus_cycle(1'b0, 1'b0, $urandom(), 1'b1, 2'b00, 32'h100);
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b10, 32'h100);
        p1_req = 1'b0; p1_wen = 1'b0;
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b01, 32'h200);
        p0_req = 1'b0;
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);

        // Outstanding limit
        p0_req = 1'b1; p0_addr = 32'h300;
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b01, 32'h300);
        p0_req = 1'b0; p1_req = 1'b1; p1_addr = 32'h400;
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b10, 32'h400);
        p1_req = 1'b0; p0_req = 1'b1; p0_addr = 32'h500;
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b0, 2'b00, 32'd0);
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b01, 32'h500);
        p0_req = 1'b0;
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);

        // Interleaved order with a simultaneous push/pop
        p0_req = 1'b1; p0_addr = 32'h600;
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b01, 32'h600);
        p0_req = 1'b0; p1_req = 1'b1; p1_addr = 32'h700;
        bus_cycle(1'b1, 1'b1, $urandom(), 1'b1, 2'b10, 32'h700);
        p1_req = 1'b0; p0_req = 1'b1; p0_addr = 32'h800;
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b01, 32'h800);
        p0_req = 1'b0; p1_req = 1'b1; p1_addr = 32'h900;
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b0, 2'b00, 32'd0);
        p1_req = 1'b0;
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);
        check("drain_interleave", 32'(exp_q.size()), 32'd0);

        // Spurious response
        check("arb_err_clear", arb_err, 1'b0);
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);
        check("arb_err_set", arb_err, 1'b1);
        for (int i = 0; i < 3; i++) bus_cycle(1'b0, 1'b0, $urandom(), 1'b0, 2'b00, 32'd0);
        check("arb_err_sticky", arb_err, 1'b1);
        do_reset();
        check("arb_err_reset", arb_err, 1'b0);

        // Reset mid-transaction: a late response is spurious
        p0_req = 1'b1; p0_addr = 32'hA00;
        bus_cycle(1'b0, 1'b0, $urandom(), 1'b1, 2'b00, 32'hA00);
        check("pre_reset_lock", dbg_state, 2'd1);
        bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, 2'b01, 32'hA00);
        p0_req = 1'b0;
        do_reset();
        check("mid_reset_state", dbg_state, 2'd0);
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);
        check("late_resp_arb_err", arb_err, 1'b1);
        do_reset();

        // Both ports requesting, grant every other cycle
        p0_req = 1'b1; p0_addr = 32'hB00;
        p1_req = 1'b1; p1_addr = 32'hC00;
        p1_wait = 0;
        exp_sel = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 0 || (i % 2) == 1) exp_sel = AGING && (p1_wait >= 8);
            p1_granted = ((i % 2) == 0) && exp_sel;
            if ((i % 2) == 0) begin
                bus_cycle(1'b1, 1'b0, $urandom(), 1'b1, exp_sel ? 2'b10 : 2'b01,
                          exp_sel ? 32'hC00 : 32'hB00);
            end else begin
                bus_cycle(1'b0, 1'b1, $urandom(), 1'b1, 2'b00,
                          exp_sel ? 32'hC00 : 32'hB00);
            end
            p1_wait = p1_granted ? 0 : ((p1_wait < 15) ? p1_wait + 1 : 15);
        end
        p0_req = 1'b0; p1_req = 1'b0;
        bus_cycle(1'b0, 1'b1, $urandom(), 1'b0, 2'b00, 32'd0);
        check("drain_final", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
